// File: rtl/mnist_pkg.sv
// Shared sizing, derived address widths and the sequencer state type for the
// two-layer MNIST inference control path.
package mnist_pkg;

    localparam int DEF_N_PIX = 784;
    localparam int DEF_N_HID = 32;
    localparam int DEF_N_OUT = 10;
    localparam int DEF_ACC_W = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int BUF_AW  = $clog2(DEF_N_PIX);
    localparam int WROM_AW = $clog2(DEF_N_PIX * DEF_N_HID);
    localparam int HID_AW  = $clog2(DEF_N_HID);
    localparam int CLS_W   = $clog2(DEF_N_OUT);

    typedef enum logic [2:0] {
        S_LOAD,
        S_L1,
        S_L2,
        S_FIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Pixel stream, buffer/ROM/MAC control and result signals between the
// sequencer (master) and the image source / datapath (slave).
interface nn_layer_sequencer_if #(
    parameter int ACC_W = mnist_pkg::DEF_ACC_W
);
    import mnist_pkg::*;

    logic                     pix_valid;
    logic [7:0]               pix_data;
    logic                     pix_ready;
    logic                     buf_we;
    logic [BUF_AW-1:0]        buf_waddr;
    logic [7:0]               buf_wdata;
    logic                     rd_sel;
    logic [BUF_AW-1:0]        rd_addr;
    logic [WROM_AW-1:0]       w_addr;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc_in;
    logic                     hid_we;
    logic [HID_AW-1:0]        hid_waddr;
    logic [CLS_W-1:0]         prediction;
    logic                     valid_out;
    logic                     busy;

    modport master (
        input  pix_valid, pix_data, acc_in,
        output pix_ready, buf_we, buf_waddr, buf_wdata, rd_sel, rd_addr, w_addr,
               mac_clr, mac_en, hid_we, hid_waddr, prediction, valid_out, busy
    );

    modport slave (
        output pix_valid, pix_data, acc_in,
        input  pix_ready, buf_we, buf_waddr, buf_wdata, rd_sel, rd_addr, w_addr,
               mac_clr, mac_en, hid_we, hid_waddr, prediction, valid_out, busy
    );

endinterface

// File: rtl/nn_layer_sequencer_argmax_tracker.sv
// Running signed argmax over the output-layer scores; ties keep the lowest index
// because only a strictly greater score replaces the held maximum.
module argmax_tracker
    import mnist_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int IDX_W = CLS_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    score_valid,
    input  logic signed [ACC_W-1:0] score,
    input  logic [IDX_W-1:0]        index,
    output logic [IDX_W-1:0]        result
);

    logic signed [ACC_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]        result_q, result_d;

    always_comb begin
        max_d    = max_q;
        result_d = result_q;
        if (score_valid && (start || (score > max_q))) begin
            max_d    = score;
            result_d = index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q    <= '0;
            result_q <= '0;
        end else begin
            max_q    <= max_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Control FSM for the 784->N_HID->10 MNIST datapath: loads one image, walks both
// fully connected layers one MAC issue per cycle and reports the argmax class.
module nn_layer_sequencer
    import mnist_pkg::*;
#(
    parameter int N_PIX = DEF_N_PIX,
    parameter int N_HID = DEF_N_HID,
    parameter int N_OUT = DEF_N_OUT,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_layer_sequencer_if.master bus
);

    localparam int CNT_W  = BUF_AW;
    localparam int OUT_CW = max_int(HID_AW, CLS_W);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    inner_q, inner_d;
    logic [OUT_CW-1:0]   outer_q, outer_d;
    logic [WROM_AW-1:0]  w_q, w_d;
    logic                drain_q, drain_d;
    logic                pix_ready_q, pix_ready_d;
    logic                buf_we_q, buf_we_d;
    logic [BUF_AW-1:0]   buf_waddr_q, buf_waddr_d;
    logic [7:0]          buf_wdata_q, buf_wdata_d;
    logic                mac_en_q, mac_en_d;
    logic                mac_clr_q, mac_clr_d;
    logic                last1_q, last1_d, last2_q, last2_d;
    logic                l2a_q, l2a_d, l2b_q, l2b_d;
    logic [OUT_CW-1:0]   idx1_q, idx1_d, idx2_q, idx2_d;
    logic [CLS_W-1:0]    pred_hold_q, pred_hold_d;
    logic [CLS_W-1:0]    best_idx;
    logic                issue, inner_last, outer_last;

    assign issue      = (state_q == S_L1) || (state_q == S_L2);
    assign inner_last = (state_q == S_L1) ? (inner_q == CNT_W'(N_PIX - 1))
                                          : (inner_q == CNT_W'(N_HID - 1));
    assign outer_last = (state_q == S_L1) ? (outer_q == OUT_CW'(N_HID - 1))
                                          : (outer_q == OUT_CW'(N_OUT - 1));

    always_comb begin
        state_d     = state_q;
        inner_d     = inner_q;
        outer_d     = outer_q;
        w_d         = w_q;
        drain_d     = drain_q;
        pix_ready_d = pix_ready_q;
        buf_we_d    = 1'b0;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;
        pred_hold_d = pred_hold_q;
        // Issue -> operand (mac_en) -> accumulator valid: two-stage completion pipe.
        mac_en_d    = issue;
        mac_clr_d   = issue && (inner_q == '0);
        last1_d     = issue && inner_last;
        l2a_d       = (state_q == S_L2);
        idx1_d      = outer_q;
        last2_d     = last1_q;
        l2b_d       = l2a_q;
        idx2_d      = idx1_q;

        case (state_q)
            S_LOAD: begin
                pix_ready_d = 1'b1;
                if (bus.pix_valid && pix_ready_q) begin
                    buf_we_d    = 1'b1;
                    buf_waddr_d = inner_q;
                    buf_wdata_d = bus.pix_data;
                    if (inner_q == CNT_W'(N_PIX - 1)) begin
                        inner_d     = '0;
                        pix_ready_d = 1'b0;
                        state_d     = S_L1;
                    end else begin
                        inner_d = inner_q + 1'b1;
                    end
                end
            end
            S_L1, S_L2: begin
                // Weight addresses are contiguous within a layer, so a running counter suffices.
                w_d = w_q + 1'b1;
                if (inner_last) begin
                    inner_d = '0;
                    if (outer_last) begin
                        outer_d = '0;
                        w_d     = '0;
                        state_d = (state_q == S_L1) ? S_L2 : S_FIN;
                    end else begin
                        outer_d = outer_q + 1'b1;
                    end
                end else begin
                    inner_d = inner_q + 1'b1;
                end
            end
            S_FIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                pred_hold_d = best_idx;
                pix_ready_d = 1'b1;
                state_d     = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            inner_q     <= '0;
            outer_q     <= '0;
            w_q         <= '0;
            drain_q     <= 1'b0;
            pix_ready_q <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            last1_q     <= 1'b0;
            last2_q     <= 1'b0;
            l2a_q       <= 1'b0;
            l2b_q       <= 1'b0;
            idx1_q      <= '0;
            idx2_q      <= '0;
            pred_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            inner_q     <= inner_d;
            outer_q     <= outer_d;
            w_q         <= w_d;
            drain_q     <= drain_d;
            pix_ready_q <= pix_ready_d;
            buf_we_q    <= buf_we_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            last1_q     <= last1_d;
            last2_q     <= last2_d;
            l2a_q       <= l2a_d;
            l2b_q       <= l2b_d;
            idx1_q      <= idx1_d;
            idx2_q      <= idx2_d;
            pred_hold_q <= pred_hold_d;
        end
    end

    argmax_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (CLS_W)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .start       (idx2_q == '0),
        .score_valid (last2_q && l2b_q),
        .score       (bus.acc_in),
        .index       (idx2_q[CLS_W-1:0]),
        .result      (best_idx)
    );

    assign bus.pix_ready  = pix_ready_q;
    assign bus.buf_we     = buf_we_q;
    assign bus.buf_waddr  = buf_waddr_q;
    assign bus.buf_wdata  = buf_wdata_q;
    assign bus.rd_sel     = (state_q == S_L2);
    assign bus.rd_addr    = issue ? inner_q : '0;
    assign bus.w_addr     = w_q;
    assign bus.mac_en     = mac_en_q;
    assign bus.mac_clr    = mac_clr_q;
    assign bus.hid_we     = last2_q && !l2b_q;
    assign bus.hid_waddr  = idx2_q[HID_AW-1:0];
    // The fresh argmax is shown during DONE; afterwards the held copy is.
    assign bus.prediction = (state_q == S_DONE) ? best_idx : pred_hold_q;
    assign bus.valid_out  = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_LOAD);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: stimulus pushes expected events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_nn_layer_sequencer;
    import mnist_pkg::*;

    localparam int N_PIX  = DEF_N_PIX;
    localparam int N_HID  = DEF_N_HID;
    localparam int N_OUT  = DEF_N_OUT;
    localparam int ACC_W  = DEF_ACC_W;
    localparam int L1_LEN = N_PIX * N_HID;
    localparam int L2_LEN = N_OUT * N_HID;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    nn_layer_sequencer_if #(.ACC_W(ACC_W)) bus ();

    nn_layer_sequencer #(
        .N_PIX (N_PIX),
        .N_HID (N_HID),
        .N_OUT (N_OUT),
        .ACC_W (ACC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; int val; } ev_t;
    typedef struct { int cyc; int sig; longint val; } probe_t;

    wr_t    wr_q[$];
    ev_t    hid_q[$];
    ev_t    out_q[$];
    probe_t probe_q[$];
    int     scores[N_OUT];
    int     img_c = -1;
    int     n_checks = 0;
    int     n_pass = 0;
    int     n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic longint sig_val(input int s);
        case (s)
            0: return longint'(bus.pix_ready);
            1: return longint'(bus.busy);
            2: return longint'(bus.rd_sel);
            3: return longint'(bus.rd_addr);
            4: return longint'(bus.w_addr);
            5: return longint'(bus.mac_en);
            6: return longint'(bus.mac_clr);
            7: return longint'(bus.valid_out);
            8: return longint'(bus.prediction);
            9: return longint'(bus.buf_we);
            10: return longint'(bus.hid_we);
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            0: return "pix_ready";
            1: return "busy";
            2: return "rd_sel";
            3: return "rd_addr";
            4: return "w_addr";
            5: return "mac_en";
            6: return "mac_clr";
            7: return "valid_out";
            8: return "prediction";
            9: return "buf_we";
            10: return "hid_we";
            default: return "unknown";
        endcase
    endfunction

    task automatic add_probe(input int c, input int s, input longint v);
        probe_q.push_back('{c, s, v});
    endtask

    // Reference argmax: the lowest class index holding the maximum signed score.
    function automatic int ref_argmax();
        int mx = scores[0];
        for (int i = 1; i < N_OUT; i++) if (scores[i] > mx) mx = scores[i];
        for (int i = 0; i < N_OUT; i++) if (scores[i] == mx) return i;
        return -1;
    endfunction

    task automatic set_scores(input int kind);
        int mx;
        for (int i = 0; i < N_OUT; i++) begin
            case (kind)
                0: scores[i] = int'($urandom_range(2000000, 0)) - 1000000;
                1: scores[i] = -1 - int'($urandom_range(1000000000, 0));
                default: scores[i] = int'($urandom);
            endcase
        end
        if (kind == 0) begin
            mx = -2000000;
            for (int i = 0; i < N_OUT; i++) if (i != 7 && scores[i] > mx) mx = scores[i];
            scores[7] = mx + 1 + int'($urandom_range(100, 0));
        end else if (kind == 1) begin
            scores[2] = -5 - int'($urandom_range(50, 0));
            scores[5] = scores[2];
        end
    endtask

    task automatic flush_all();
        wr_q.delete();
        hid_q.delete();
        out_q.delete();
        probe_q.delete();
        img_c = -1;
    endtask

    task automatic send_image(input int pct, input bit ramp, input bit extra, input int abort_at);
        int acc = 0;
        int budget = 0;
        int c = 0;
        int t_last;
        bit v;
        logic [7:0] px;
        @(posedge clk); #1;
        while (acc < N_PIX && budget < 20000) begin
            v  = ($urandom_range(99, 0) < pct);
            px = ramp ? 8'(acc) : 8'($urandom);
            bus.pix_valid = v;
            bus.pix_data  = px;
            if (v && bus.pix_ready) begin
                wr_q.push_back('{cyc + 1, acc, int'(px)});
                c = cyc;
                acc++;
            end
            @(posedge clk); #1;
            budget++;
        end
        check("pixels_accepted", acc, N_PIX);
        if (acc < N_PIX) begin
            bus.pix_valid = 1'b0;
            return;
        end
        img_c  = c;
        t_last = c + L1_LEN + L2_LEN;
        for (int n = 0; n < N_HID; n++) hid_q.push_back('{c + (n + 1) * N_PIX + 2, n});
        out_q.push_back('{t_last + 3, ref_argmax()});
        add_probe(c + 1, 0, 0);
        add_probe(c + 1, 1, 1);
        add_probe(c + 1, 2, 0);
        add_probe(c + 1, 3, 0);
        add_probe(c + 1, 4, 0);
        add_probe(c + 2, 5, 1);
        add_probe(c + 2, 6, 1);
        add_probe(c + 3, 5, 1);
        add_probe(c + 3, 6, 0);
        add_probe(c + N_PIX + 1, 4, N_PIX);
        add_probe(c + N_PIX + 1, 3, 0);
        add_probe(c + N_PIX + 2, 6, 1);
        add_probe(c + L1_LEN + 1, 2, 1);
        add_probe(c + L1_LEN + 1, 4, 0);
        add_probe(c + L1_LEN + N_HID + 2, 3, 1);
        add_probe(c + L1_LEN + N_HID + 2, 4, N_HID + 1);
        add_probe(t_last + 1, 5, 1);
        add_probe(t_last + 2, 5, 0);
        add_probe(t_last + 2, 1, 1);
        add_probe(t_last + 4, 0, 1);
        add_probe(t_last + 4, 1, 0);
        add_probe(t_last + 4, 7, 0);
        add_probe(t_last + 4, 8, ref_argmax());
        if (extra) begin
            bus.pix_valid = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #1;
            rst = 1'b1;
            flush_all();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("abort_busy_cleared", longint'(bus.busy), 0);
            check("abort_no_valid_out", longint'(bus.valid_out), 0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (out_q.size() != 0 && n < 30000) begin
            @(posedge clk);
            n++;
        end
        check("image_completed_in_budget", out_q.size(), 0);
        repeat (6) @(posedge clk);
    endtask

    // Datapath stand-in: acc_in carries output neuron o's score while it is sampled.
    initial begin : acc_driver
        int j;
        bus.acc_in = '0;
        forever begin
            @(posedge clk); #1;
            j = cyc - (img_c + L1_LEN + 3);
            if (img_c >= 0 && j >= 0 && j < L2_LEN) bus.acc_in = scores[j / N_HID];
            else bus.acc_in = $urandom;
        end
    end

    always @(negedge clk) begin : monitor
        wr_t    w;
        ev_t    e;
        probe_t p;
        if (!rst) begin
            if (bus.buf_we) begin
                check("buf_we_expected", longint'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("buf_write_cycle", cyc, w.cyc);
                    check("buf_waddr", longint'(bus.buf_waddr), w.addr);
                    check("buf_wdata", longint'(bus.buf_wdata), w.data);
                end
            end
            if (bus.hid_we) begin
                check("hid_we_expected", longint'(hid_q.size() != 0), 1);
                if (hid_q.size() != 0) begin
                    e = hid_q.pop_front();
                    check("hid_we_cycle", cyc, e.cyc);
                    check("hid_waddr", longint'(bus.hid_waddr), e.val);
                end
            end
            if (bus.valid_out) begin
                check("valid_out_expected", longint'(out_q.size() != 0), 1);
                if (out_q.size() != 0) begin
                    e = out_q.pop_front();
                    $display("image result: prediction=%0d expected=%0d cycle=%0d expected_cycle=%0d",
                             bus.prediction, e.val, cyc, e.cyc);
                    check("valid_out_cycle", cyc, e.cyc);
                    check("prediction", longint'(bus.prediction), e.val);
                end
            end
            while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
                p = probe_q.pop_front();
                check({"probe_", sig_name(p.sig)}, (p.cyc == cyc) ? sig_val(p.sig) : -2, p.val);
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s <= 10; s++) check({"reset_", sig_name(s)}, sig_val(s), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pix_ready_after_release", longint'(bus.pix_ready), 1);
        check("busy_after_release", longint'(bus.busy), 0);

        // Ramp image, mixed-sign scores peaking at class 7, extra beat past the end.
        set_scores(0);
        send_image(100, 1'b1, 1'b1, 0);
        wait_done();

        // Gapped image aborted by reset early in layer 1.
        set_scores(2);
        send_image(50, 1'b0, 1'b0, 1000);

        // Gapped image, all-negative scores with an equal maximum at classes 2 and 5.
        set_scores(1);
        send_image(50, 1'b0, 1'b0, 0);
        wait_done();

        check("pending_buf_writes", wr_q.size(), 0);
        check("pending_hid_writes", hid_q.size(), 0);
        check("pending_probes", probe_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
